fetch_stage: RTL

Instruction-fetch stage of the 5-stage pipelined CPU: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes its `PcWrite` and `IF_ID_Write` stall controls. It also accepts the branch/jump redirect resolved in EX and flushes the wrong-path instruction held in IF/ID.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, EX redirect/flush and stall handling.
// Optional stall/flush statistics counters are built when FETCH_STATS_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PcWrite,
  input  logic        IF_ID_Write,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PcPlus4,
  output logic        IF_ID_Valid,
  output logic        Misaligned,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic        r_misaligned;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_plus4_nxt;
  logic        w_valid_nxt;
  logic        w_misaligned_nxt;
  logic [31:0] w_pc_inc;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_pc_inc = r_pc + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_plus4   <= 32'h0000_0000;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_pc_plus4   <= w_pc_plus4_nxt;
      r_valid      <= w_valid_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  // BOOT spends one edge letting imem_data settle for RESET_PC; redirects there are dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_pc_plus4_nxt   = r_pc_plus4;
    w_valid_nxt      = r_valid;
    w_misaligned_nxt = 1'b0;
    w_stall_evt      = 1'b0;
    w_flush_evt      = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        w_state_nxt = RUN;
        if (Redirect) begin
          // The stalled instruction is wrong-path, so redirect beats both stall controls.
          w_pc_nxt         = {Redirect_Target[31:2], 2'b00};
          w_instr_nxt      = NOP_INSTR;
          w_pc_plus4_nxt   = 32'h0000_0000;
          w_valid_nxt      = 1'b0;
          w_misaligned_nxt = |Redirect_Target[1:0];
          w_flush_evt      = 1'b1;
        end else begin
          if (PcWrite) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            w_pc_nxt    = r_pc;
            w_stall_evt = 1'b1;
          end
          if (IF_ID_Write) begin
            w_instr_nxt    = imem_data;
            w_pc_plus4_nxt = w_pc_inc;
            w_valid_nxt    = 1'b1;
          end else begin
            w_instr_nxt    = r_instr;
            w_pc_plus4_nxt = r_pc_plus4;
            w_valid_nxt    = r_valid;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : (value + 16'd1);
  endfunction

  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (w_stall_evt) begin
        r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
      if (w_flush_evt) begin
        r_flush_cnt <= sat_inc16(r_flush_cnt);
      end
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_stall_evt ^ w_flush_evt;
  assign StallCount     = 16'h0000;
  assign FlushCount     = 16'h0000;
`endif

  assign pc            = r_pc;
  assign imem_addr     = r_pc;
  assign IF_ID_Instr   = r_instr;
  assign IF_ID_PcPlus4 = r_pc_plus4;
  assign IF_ID_Valid   = r_valid;
  assign Misaligned    = r_misaligned;

endmodule
